// File: rtl/br_unit_pipe.sv
// br_unit_pipe: pipelined branch/jump resolution unit for one issue port.
// Resolves JAL/JALR/conditional branches, flags mispredictions against the
// front-end prediction and misaligned taken targets, and carries results
// through LATENCY valid-tagged stages with valid/ready back-pressure.
module br_unit_pipe #(
  parameter int XLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int ROB_IDX_W = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 cnt_clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_rs1,
  input  logic [XLEN-1:0]      in_rs2,
  input  logic [XLEN-1:0]      in_pred_pc,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [4:0]           in_rd_addr,
  input  logic                 in_regf_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rd_data,
  output logic                 out_br_en,
  output logic [XLEN-1:0]      out_next_pc,
  output logic                 out_mispredict,
  output logic                 out_misaligned,
  output logic                 out_illegal,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [4:0]           out_rd_addr,
  output logic                 out_regf_we,
  output logic [CNT_W-1:0]     cnt_resolved,
  output logic [CNT_W-1:0]     cnt_mispred
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rd_data;
    logic [XLEN-1:0]      next_pc;
    logic                 br_en;
    logic                 mispredict;
    logic                 misaligned;
    logic                 illegal;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [4:0]           rd_addr;
    logic                 regf_we;
  } stage_t;

  // Conditional branch compare; funct3 010/011 are not branches and never take.
  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic                   r;
    sa = a;
    sb = b;
    r  = 1'b0;
    case (f3)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b100:  r = (sa < sb);
      3'b101:  r = (sa >= sb);
      3'b110:  r = (a < b);
      3'b111:  r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic                 taken_s0;
  logic                 illegal_s0;
  logic [XLEN-1:0]      pc4_s0;
  logic [XLEN-1:0]      target_s0;
  logic [XLEN-1:0]      link_s0;
  logic [XLEN-1:0]      next_pc_s0;
  stage_t               res_s0;

  logic [LATENCY-1:0]   vld_q, vld_d;
  logic [LATENCY-1:0]   load;
  stage_t               pl_q [LATENCY];
  stage_t               pl_d [LATENCY];
  logic                 rdy_en_q, rdy_en_d;
  logic [CNT_W-1:0]     cnt_res_q, cnt_res_d;
  logic [CNT_W-1:0]     cnt_mis_q, cnt_mis_d;
  logic                 accept;
  logic                 out_hs;

  // Stage 0: resolve direction, target, link and prediction check from the inputs.
  always_comb begin
    pc4_s0     = in_pc + XLEN'(4);
    target_s0  = in_pc + in_imm;
    link_s0    = '0;
    taken_s0   = 1'b0;
    illegal_s0 = 1'b0;
    case (in_opcode)
      OP_JAL: begin
        taken_s0 = 1'b1;
        link_s0  = pc4_s0;
      end
      OP_JALR: begin
        taken_s0  = 1'b1;
        target_s0 = (in_rs1 + in_imm) & ~XLEN'(1);
        link_s0   = pc4_s0;
      end
      OP_BRANCH: taken_s0 = br_taken(in_funct3, in_rs1, in_rs2);
      default:   illegal_s0 = 1'b1;
    endcase
    next_pc_s0          = taken_s0 ? target_s0 : pc4_s0;
    res_s0.pc           = in_pc;
    res_s0.rd_data      = link_s0;
    res_s0.next_pc      = next_pc_s0;
    res_s0.br_en        = taken_s0;
    res_s0.mispredict   = (next_pc_s0 != in_pred_pc);
    res_s0.misaligned   = taken_s0 & (target_s0[1:0] != 2'b00);
    res_s0.illegal      = illegal_s0;
    res_s0.rob_idx      = in_rob_idx;
    res_s0.rd_addr      = in_rd_addr;
    res_s0.regf_we      = in_regf_we & ~illegal_s0;
  end

  // Stage load enables: a stage loads when empty or when the next stage loads.
  always_comb begin
    logic nxt;
    nxt  = out_ready;
    load = '0;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      nxt     = ~vld_q[i] | nxt;
      load[i] = nxt;
    end
  end

  assign in_ready = rdy_en_q & load[0];
  assign accept   = in_valid & in_ready & ~flush;
  // A handshake on a flush edge is dropped along with everything else.
  assign out_hs   = vld_q[LATENCY-1] & out_ready & ~flush & ~pl_q[LATENCY-1].illegal;

  // Next-state of the stage registers; payload only moves with a valid op.
  always_comb begin
    vld_d    = vld_q;
    pl_d     = pl_q;
    rdy_en_d = 1'b1;
    if (load[0]) begin
      vld_d[0] = accept;
      if (accept) pl_d[0] = res_s0;
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (load[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) pl_d[i] = pl_q[i-1];
      end
    end
    if (flush) vld_d = '0;
  end

  // Performance counters; clear wins over a same-edge increment.
  always_comb begin
    cnt_res_d = cnt_res_q;
    cnt_mis_d = cnt_mis_q;
    if (cnt_clr) begin
      cnt_res_d = '0;
      cnt_mis_d = '0;
    end else if (out_hs) begin
      cnt_res_d = sat_inc(cnt_res_q);
      if (pl_q[LATENCY-1].mispredict) cnt_mis_d = sat_inc(cnt_mis_q);
    end
  end

  // State registers with asynchronous clear of control, payload and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= '0;
      rdy_en_q  <= 1'b0;
      cnt_res_q <= '0;
      cnt_mis_q <= '0;
      for (int i = 0; i < LATENCY; i++) pl_q[i] <= '0;
    end else begin
      vld_q     <= vld_d;
      rdy_en_q  <= rdy_en_d;
      cnt_res_q <= cnt_res_d;
      cnt_mis_q <= cnt_mis_d;
      pl_q      <= pl_d;
    end
  end

  assign out_valid      = vld_q[LATENCY-1];
  assign out_pc         = pl_q[LATENCY-1].pc;
  assign out_rd_data    = pl_q[LATENCY-1].rd_data;
  assign out_br_en      = pl_q[LATENCY-1].br_en;
  assign out_next_pc    = pl_q[LATENCY-1].next_pc;
  assign out_mispredict = pl_q[LATENCY-1].mispredict;
  assign out_misaligned = pl_q[LATENCY-1].misaligned;
  assign out_illegal    = pl_q[LATENCY-1].illegal;
  assign out_rob_idx    = pl_q[LATENCY-1].rob_idx;
  assign out_rd_addr    = pl_q[LATENCY-1].rd_addr;
  assign out_regf_we    = pl_q[LATENCY-1].regf_we;
  assign cnt_resolved   = cnt_res_q;
  assign cnt_mispred    = cnt_mis_q;

endmodule

// File: tb/tb_br_unit_pipe.sv
// tb_br_unit_pipe: scoreboard bench for br_unit_pipe (LATENCY=2, CNT_W=4).
module tb_br_unit_pipe;
  localparam int XLEN = 32;
  localparam int LAT  = 2;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam logic [6:0] OP_JAL = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63;
  localparam logic [6:0] OP_ALU = 7'h33;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [6:0] in_opcode = '0;
  logic [2:0] in_funct3 = '0;
  logic [XLEN-1:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0, in_pred_pc = '0;
  logic [RW-1:0] in_rob_idx = '0, out_rob_idx;
  logic [4:0] in_rd_addr = '0, out_rd_addr;
  logic in_regf_we = 1'b0, out_regf_we;
  logic [XLEN-1:0] out_pc, out_rd_data, out_next_pc;
  logic out_br_en, out_mispredict, out_misaligned, out_illegal;
  logic [CW-1:0] cnt_resolved, cnt_mispred;

  typedef struct {
    logic [31:0] pc, rd_data, next_pc;
    logic br_en, mis, mal, ill, we;
    logic [4:0] rob, rd;
    int acc;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0;
  logic [CW-1:0] m_res = '0, m_mis = '0;
  logic seen_edge = 1'b0;
  bit rand_rdy = 1'b0;
  logic [CW-1:0] saved_res, saved_mis;

  br_unit_pipe #(.XLEN(XLEN), .LATENCY(LAT), .ROB_IDX_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pred_pc(in_pred_pc),
    .in_rob_idx(in_rob_idx), .in_rd_addr(in_rd_addr), .in_regf_we(in_regf_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd_data(out_rd_data),
    .out_br_en(out_br_en), .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
    .out_misaligned(out_misaligned), .out_illegal(out_illegal), .out_rob_idx(out_rob_idx),
    .out_rd_addr(out_rd_addr), .out_regf_we(out_regf_we),
    .cnt_resolved(cnt_resolved), .cnt_mispred(cnt_mispred)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst) if (!rst) seen_edge <= 1'b0; else seen_edge <= 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the instruction semantics.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] pc, imm, rs1, rs2, pred,
                                 input logic [4:0] rob, rd, input logic we);
    exp_t e;
    bit taken;
    logic [31:0] tgt;
    taken = 0;
    tgt = pc + imm;
    e.ill = 0;
    e.rd_data = 32'd0;
    if (op == OP_JAL) begin
      taken = 1; e.rd_data = pc + 32'd4;
    end else if (op == OP_JALR) begin
      tgt = rs1 + imm; tgt[0] = 1'b0; taken = 1; e.rd_data = pc + 32'd4;
    end else if (op == OP_BR) begin
      case (f3)
        3'd0: taken = (rs1 == rs2);
        3'd1: taken = (rs1 != rs2);
        3'd4: taken = ($signed(rs1) < $signed(rs2));
        3'd5: taken = ($signed(rs1) >= $signed(rs2));
        3'd6: taken = (rs1 < rs2);
        3'd7: taken = (rs1 >= rs2);
        default: taken = 0;
      endcase
    end else e.ill = 1;
    e.br_en = taken;
    e.next_pc = taken ? tgt : pc + 32'd4;
    e.mis = (e.next_pc != pred);
    e.mal = taken && (tgt[1:0] != 2'b00);
    e.we = we && !e.ill;
    e.pc = pc; e.rob = rob; e.rd = rd; e.acc = 0;
    return e;
  endfunction

  // Monitor / scoreboard: compares every presented output against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete(); m_res = '0; m_mis = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_next_pc", out_next_pc, 0);
      chk("rst_cnt_resolved", cnt_resolved, 0);
      chk("rst_cnt_mispred", cnt_mispred, 0);
    end else begin
      bit exp_ov;
      exp_t e;
      exp_ov = (q.size() > 0) && (cyc >= q[0].acc + LAT - 1);
      chk("in_ready", in_ready, seen_edge && (out_ready || q.size() < LAT));
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov && out_valid) begin
        e = q[0];
        chk("out_pc", out_pc, e.pc);
        chk("out_rd_data", out_rd_data, e.rd_data);
        chk("out_next_pc", out_next_pc, e.next_pc);
        chk("out_br_en", out_br_en, e.br_en);
        chk("out_mispredict", out_mispredict, e.mis);
        chk("out_misaligned", out_misaligned, e.mal);
        chk("out_illegal", out_illegal, e.ill);
        chk("out_regf_we", out_regf_we, e.we);
        chk("out_rob_idx", out_rob_idx, e.rob);
        chk("out_rd_addr", out_rd_addr, e.rd);
      end
      chk("cnt_resolved", cnt_resolved, m_res);
      chk("cnt_mispred", cnt_mispred, m_mis);
      if (flush) q.delete();
      else if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        if (!e.ill) begin
          if (m_res != '1) m_res = m_res + 1'b1;
          if (e.mis && m_mis != '1) m_mis = m_mis + 1'b1;
        end
      end
      if (cnt_clr) begin m_res = '0; m_mis = '0; end
      if (!flush && in_valid && in_ready) begin
        e = model(in_opcode, in_funct3, in_pc, in_imm, in_rs1, in_rs2, in_pred_pc,
                  in_rob_idx, in_rd_addr, in_regf_we);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  // Random consumer back-pressure and occasional counter clears.
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 15) == 0);
    end
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, imm, rs1, rs2, pred, input logic we);
    bit ok;
    in_opcode = op; in_funct3 = f3; in_pc = pc; in_imm = imm; in_rs1 = rs1;
    in_rs2 = rs2; in_pred_pc = pred; in_regf_we = we;
    in_rob_idx = 5'($urandom); in_rd_addr = 5'($urandom);
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready=1");
    end
  endtask

  task automatic issue_rand();
    logic [6:0] op;
    logic [31:0] pc, imm, rs1, rs2, pred;
    int s, p;
    s = $urandom_range(0, 9);
    op = (s < 2) ? OP_JAL : (s < 4) ? OP_JALR : (s < 9) ? OP_BR : OP_ALU;
    pc = $urandom & 32'hFFFF_FFFC;
    imm = $urandom;
    imm = imm[15] ? (imm | 32'hFFFF_0000) : (imm & 32'h0000_FFFF);
    rs1 = $urandom;
    rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
    p = $urandom_range(0, 3);
    pred = (p == 0) ? pc + 32'd4 : (p == 1) ? pc + imm : (p == 2) ? ((rs1 + imm) & ~32'd1) : $urandom;
    issue(op, 3'($urandom), pc, imm, rs1, rs2, pred, 1'($urandom));
  endtask

  task automatic wait_out(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = out_valid;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got out_valid=0 expected out_valid=1", name);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && q.size() > 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic clr_pulse();
    cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk("in_ready_before_first_edge", in_ready, 0);
    @(posedge clk); #1 chk("in_ready_after_first_edge", in_ready, 1);

    // JAL with wrong prediction
    issue(OP_JAL, 3'd0, 32'h100, 32'h20, 32'h0, 32'h0, 32'h104, 1'b1);
    wait_out("jal");
    chk("jal_br_en", out_br_en, 1);
    chk("jal_next_pc", out_next_pc, 32'h120);
    chk("jal_rd_data", out_rd_data, 32'h104);
    chk("jal_mispredict", out_mispredict, 1);
    @(posedge clk); #1 chk("jal_cnt_mispred", cnt_mispred, 1);

    // JALR misaligned / aligned targets
    issue(OP_JALR, 3'd0, 32'h400, 32'h4, 32'h203, 32'h0, 32'h206, 1'b1);
    wait_out("jalr1");
    chk("jalr1_next_pc", out_next_pc, 32'h206);
    chk("jalr1_mispredict", out_mispredict, 0);
    chk("jalr1_misaligned", out_misaligned, 1);
    @(posedge clk); #1;
    issue(OP_JALR, 3'd0, 32'h400, 32'h4, 32'h200, 32'h0, 32'h206, 1'b1);
    wait_out("jalr2");
    chk("jalr2_next_pc", out_next_pc, 32'h204);
    chk("jalr2_misaligned", out_misaligned, 0);
    @(posedge clk); #1;

    // Signed vs unsigned compares, equality on bge
    issue(OP_BR, 3'd4, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    wait_out("blt");
    chk("blt_br_en", out_br_en, 1);
    chk("blt_next_pc", out_next_pc, 32'h340);
    @(posedge clk); #1;
    issue(OP_BR, 3'd6, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    wait_out("bltu");
    chk("bltu_br_en", out_br_en, 0);
    chk("bltu_next_pc", out_next_pc, 32'h304);
    @(posedge clk); #1;
    issue(OP_BR, 3'd5, 32'h300, 32'h40, 32'h7, 32'h7, 32'h0, 1'b0);
    wait_out("bge");
    chk("bge_br_en", out_br_en, 1);
    chk("bge_next_pc", out_next_pc, 32'h340);
    @(posedge clk); #1;

    // Eight back-to-back ops with a three-cycle consumer stall
    fork
      begin for (int k = 0; k < 8; k++) issue_rand(); end
      begin
        repeat (3) @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two ops in flight and a new op presented
    clr_pulse();
    issue(OP_JAL, 3'd0, 32'h500, 32'h8, 32'h0, 32'h0, 32'h0, 1'b1);
    issue(OP_BR, 3'd0, 32'h600, 32'h8, 32'h1, 32'h1, 32'h0, 1'b0);
    saved_res = cnt_resolved; saved_mis = cnt_mispred;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk) chk("flush_out_valid", out_valid, 0);
    repeat (4) @(posedge clk); #1;
    chk("flush_cnt_resolved", cnt_resolved, saved_res);
    chk("flush_cnt_mispred", cnt_mispred, saved_mis);

    // Saturation of the 4-bit counters
    clr_pulse();
    for (int k = 0; k < 20; k++) issue(OP_BR, 3'd0, 32'h1000 + 32'(k * 4), 32'h10, 32'h1, 32'h2, 32'h1008 + 32'(k * 4), 1'b0);
    drain();
    chk("sat_cnt_mispred", cnt_mispred, 15);
    chk("sat_cnt_resolved", cnt_resolved, 15);

    // Clear concurrent with a handshake
    issue(OP_JAL, 3'd0, 32'h700, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("clr_hs_valid", out_valid, 1);
    clr_pulse();
    chk("clr_cnt_resolved", cnt_resolved, 0);
    chk("clr_cnt_mispred", cnt_mispred, 0);

    // Illegal opcode
    issue(OP_ALU, 3'd0, 32'h800, 32'h4, 32'h0, 32'h0, 32'h804, 1'b1);
    wait_out("illegal");
    chk("ill_out_illegal", out_illegal, 1);
    chk("ill_out_regf_we", out_regf_we, 0);
    @(posedge clk); #1 chk("ill_cnt_resolved", cnt_resolved, 0);

    // Randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      issue_rand();
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rand_rdy = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    drain();

    // Asynchronous reset with ops in flight
    issue(OP_JAL, 3'd0, 32'h900, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1);
    issue(OP_JAL, 3'd0, 32'h904, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_pc", out_pc, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_cnt_resolved", cnt_resolved, 0);
    repeat (2) @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) issue_rand();
    drain();
    chk("final_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/br_unit_pipe.md
Name: br_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle branch/jump execute unit.
- Resolves JAL, JALR and conditional branches for one issue port, between reservation station and writeback/CDB.
- Generalised in data width and pipeline depth; adds valid/ready back-pressure, flush, misprediction detection against the predicted next PC, misaligned-target flagging and saturating performance counters.

Parameters:
- XLEN, 32, data/PC width.
- LATENCY, 2, pipeline stages from accept to output (legal range 1..4).
- ROB_IDX_W, 5, ROB tag width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  kill all in-flight operations.
- cnt_clr  in  1  synchronous clear of performance counters.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept this cycle.
- in_opcode  in  7  RV32 opcode.
- in_funct3  in  3  branch compare type.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  sign-extended immediate.
- in_rs1  in  XLEN  rs1 operand.
- in_rs2  in  XLEN  rs2 operand.
- in_pred_pc  in  XLEN  front-end predicted next PC.
- in_rob_idx  in  ROB_IDX_W  ROB tag.
- in_rd_addr  in  5  destination register.
- in_regf_we  in  1  destination write enable.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_pc  out  XLEN  instruction PC.
- out_rd_data  out  XLEN  link value (pc+4 for jumps, else 0).
- out_br_en  out  1  taken.
- out_next_pc  out  XLEN  resolved next PC.
- out_mispredict  out  1  out_next_pc != predicted PC.
- out_misaligned  out  1  taken target[1:0] != 0.
- out_illegal  out  1  opcode not JAL/JALR/BRANCH.
- out_rob_idx  out  ROB_IDX_W  ROB tag.
- out_rd_addr  out  5  destination register.
- out_regf_we  out  1  write enable (forced 0 when out_illegal).
- cnt_resolved  out  CNT_W  branches/jumps retired from the unit.
- cnt_mispred  out  CNT_W  mispredictions retired from the unit.

Behaviour:
- Reset (rst=0, async): all stage valid bits = 0, counters = 0, every out_* = 0.
  - in_ready = 1 after the first rising clock with rst=1.
- Stage 0 (combinational from inputs, registered into stage 1): compute taken, target, link and mispredict.
  - JAL: taken = 1; target = pc + imm; link = pc + 4.
  - JALR: taken = 1; target = (rs1 + imm) with bit 0 cleared; link = pc + 4.
  - BRANCH: funct3 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu; funct3 010/011 → taken = 0. target = pc + imm; link = 0.
  - Other opcodes: taken = 0, out_illegal = 1, regf_we = 0.
  - next_pc = taken ? target : pc + 4.
  - mispredict = (next_pc != pred_pc).
  - misaligned = taken & (target[1:0] != 0).
  - All arithmetic is modulo 2^XLEN.
- Pipeline: LATENCY valid-tagged register stages; remaining stages carry results unchanged.
  - A stage advances when the downstream stage is empty or advancing; bubbles collapse.
  - Output stage holds while out_valid & !out_ready.
  - in_ready = !stage1_valid | stage1_advances.
  - Accept at edge t with no stall → out_valid from edge t+LATENCY-1 (LATENCY=1: registered once).
  - Full throughput of 1 op/cycle with out_ready=1.
  - All output payload is held stable while stalled.
- Flush: on a clock edge with flush=1, all stage valids clear.
  - An input handshake on that same edge is discarded.
  - Counters are unaffected.
  - out_valid = 0 in the following cycle.
- Counters update on an output handshake (out_valid & out_ready), excluding out_illegal ops:
  - cnt_resolved increments by 1.
  - cnt_mispred increments by 1 if out_mispredict.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr takes priority over increment on the same edge.
- Reset asserted mid-operation: immediate clear of all state; no partial output.

Test Plan:
- LATENCY=2: JAL pc=0x100, imm=0x20, pred=0x104 → out after 2 cycles: br_en=1, next_pc=0x120, rd_data=0x104, mispredict=1, cnt_mispred=1.
- JALR rs1=0x203, imm=0x4, pred=0x206 → next_pc=0x206, mispredict=0, misaligned=1; with rs1=0x200 → next_pc=0x204, misaligned=0.
- blt rs1=0xFFFFFFFF, rs2=1 → taken; bltu with same operands → not taken, next_pc=pc+4; bge with equal operands → taken.
- Back-to-back 8 ops with out_ready low for cycles 3-5 → no loss/duplication, in order, in_ready low while stalled, payload stable.
- flush asserted with 2 ops in flight plus in_valid=1 → out_valid=0 next cycle, none emerge later, counters unchanged.
- CNT_W=4: 20 mispredicted branches → cnt_mispred saturates at 15; cnt_clr with a concurrent handshake → reads 0. Opcode 0x33 → out_illegal=1, regf_we=0, cnt_resolved unchanged.
